// File: rtl/e203_exu_longp_wbck_buf.sv
// e203_exu_longp_wbck_buf
// Long-pipe write-back collector sitting behind the OITF. Admits only the
// completion whose itag equals the OITF retire pointer, pulses the retire
// enable and queues the result in a small FIFO that drains to the
// write-back arbiter or to the exception commit path.
// Optional macro: E203_LONGP_WBCK_EXCP_EN enables the error/exception path
// (err/badaddr/pc storage and excp_o_*). Without it errors are ignored.
module e203_exu_longp_wbck_buf #(
  parameter int NSRC      = 2,
  parameter int ITAG_W    = 1,
  parameter int XLEN      = 32,
  parameter int RFIDX_W   = 5,
  parameter int PC_W      = 32,
  parameter int BUF_DEPTH = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NSRC-1:0]        src_i_valid,
  output logic [NSRC-1:0]        src_i_ready,
  input  logic [NSRC*ITAG_W-1:0] src_i_itag,
  input  logic [NSRC*XLEN-1:0]   src_i_wdat,
  input  logic [NSRC-1:0]        src_i_err,
  input  logic [NSRC*XLEN-1:0]   src_i_badaddr,
  input  logic                   oitf_empty,
  input  logic [ITAG_W-1:0]      oitf_ret_ptr,
  input  logic [RFIDX_W-1:0]     oitf_ret_rdidx,
  input  logic                   oitf_ret_rdwen,
  input  logic                   oitf_ret_rdfpu,
  input  logic [PC_W-1:0]        oitf_ret_pc,
  output logic                   oitf_ret_ena,
  output logic                   wbck_o_valid,
  input  logic                   wbck_o_ready,
  output logic [XLEN-1:0]        wbck_o_wdat,
  output logic [RFIDX_W-1:0]     wbck_o_rdidx,
  output logic                   wbck_o_rdfpu,
  output logic                   excp_o_valid,
  input  logic                   excp_o_ready,
  output logic [XLEN-1:0]        excp_o_badaddr,
  output logic [PC_W-1:0]        excp_o_pc,
  output logic                   buf_empty
);

  localparam int PTR_W = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
  localparam int SEL_W = (NSRC > 1) ? $clog2(NSRC) : 1;
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(BUF_DEPTH - 1);

  // Per-source views and selection
  logic [NSRC-1:0]  w_match;
  logic [NSRC-1:0]  w_sel;
  logic [SEL_W-1:0] w_sel_idx;
  logic [XLEN-1:0]  w_src_wdat [NSRC];

  // FIFO control
  logic [PTR_W-1:0] r_wptr;
  logic [PTR_W-1:0] r_rptr;
  logic             r_wflag;
  logic             r_rflag;
  logic             w_ptr_eq;
  logic             w_empty;
  logic             w_full;
  logic             w_cap;
  logic             w_pop;
  logic             w_head_err;
  logic             w_head_rdwen;

  // FIFO payload
  logic [XLEN-1:0]    r_wdat  [BUF_DEPTH];
  logic [RFIDX_W-1:0] r_rdidx [BUF_DEPTH];
  logic               r_rdwen [BUF_DEPTH];
  logic               r_rdfpu [BUF_DEPTH];

`ifdef E203_LONGP_WBCK_EXCP_EN
  logic               w_src_err     [NSRC];
  logic [XLEN-1:0]    w_src_badaddr [NSRC];
  logic               r_err     [BUF_DEPTH];
  logic [XLEN-1:0]    r_badaddr [BUF_DEPTH];
  logic [PC_W-1:0]    r_pc      [BUF_DEPTH];
`endif

  // A source matches only when it carries the itag the OITF retires next
  generate
    for (genvar gi = 0; gi < NSRC; gi++) begin : g_src
      assign w_match[gi]    = src_i_valid[gi] & ~oitf_empty &
                              (src_i_itag[gi*ITAG_W +: ITAG_W] == oitf_ret_ptr);
      assign w_src_wdat[gi] = src_i_wdat[gi*XLEN +: XLEN];
`ifdef E203_LONGP_WBCK_EXCP_EN
      assign w_src_err[gi]     = src_i_err[gi];
      assign w_src_badaddr[gi] = src_i_badaddr[gi*XLEN +: XLEN];
`endif
    end
  endgenerate

  // Isolate the lowest set match bit; extra matches are a protocol error and stall
  assign w_sel = w_match & (~w_match + NSRC'(1));

  // Encode the winning source index for the payload mux
  always_comb begin
    w_sel_idx = '0;
    for (int i = NSRC - 1; i >= 0; i--) begin
      if (w_match[i]) w_sel_idx = SEL_W'(i);
    end
  end

  assign w_ptr_eq = (r_rptr == r_wptr);
  assign w_empty  = w_ptr_eq & (r_rflag == r_wflag);
  assign w_full   = w_ptr_eq & (r_rflag != r_wflag);

  // Accept and retire depend only on the buffer state, never on sink ready,
  // so there is no combinational path from the sinks back into the OITF.
  assign w_cap        = (|w_match) & ~w_full;
  assign src_i_ready  = w_sel & {NSRC{~w_full}};
  assign oitf_ret_ena = w_cap;

`ifdef E203_LONGP_WBCK_EXCP_EN
  assign w_head_err     = r_err[r_rptr];
  assign excp_o_valid   = ~w_empty & w_head_err;
  assign excp_o_badaddr = r_badaddr[r_rptr];
  assign excp_o_pc      = r_pc[r_rptr];
`else
  assign w_head_err     = 1'b0;
  assign excp_o_valid   = 1'b0;
  assign excp_o_badaddr = '0;
  assign excp_o_pc      = '0;
  // Error inputs have no effect when the exception path is compiled out
  logic w_unused_excp;
  assign w_unused_excp = ^{src_i_err, src_i_badaddr, oitf_ret_pc, excp_o_ready};
`endif

  assign w_head_rdwen = r_rdwen[r_rptr];
  assign wbck_o_valid = ~w_empty & ~w_head_err & w_head_rdwen;
  assign wbck_o_wdat  = r_wdat[r_rptr];
  assign wbck_o_rdidx = r_rdidx[r_rptr];
  assign wbck_o_rdfpu = r_rdfpu[r_rptr];
  assign buf_empty    = w_empty;

  // Head leaves on its sink's ready; a no-rd, no-error entry leaves unconditionally
  assign w_pop = ~w_empty & (w_head_err   ? excp_o_ready :
                             w_head_rdwen ? wbck_o_ready : 1'b1);

  // Pointer and wrap-flag update; a wrap from the last slot toggles the flag
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_wflag <= 1'b0;
      r_rflag <= 1'b0;
    end else begin
      if (w_cap) begin
        if (r_wptr == PTR_LAST) begin
          r_wptr  <= '0;
          r_wflag <= ~r_wflag;
        end else begin
          r_wptr <= r_wptr + PTR_W'(1);
        end
      end
      if (w_pop) begin
        if (r_rptr == PTR_LAST) begin
          r_rptr  <= '0;
          r_rflag <= ~r_rflag;
        end else begin
          r_rptr <= r_rptr + PTR_W'(1);
        end
      end
    end
  end

  // Write the selected result plus the OITF entry info at the tail
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < BUF_DEPTH; i++) begin
        r_wdat[i]  <= '0;
        r_rdidx[i] <= '0;
        r_rdwen[i] <= 1'b0;
        r_rdfpu[i] <= 1'b0;
      end
    end else if (w_cap) begin
      r_wdat[r_wptr]  <= w_src_wdat[w_sel_idx];
      r_rdidx[r_wptr] <= oitf_ret_rdidx;
      r_rdwen[r_wptr] <= oitf_ret_rdwen;
      r_rdfpu[r_wptr] <= oitf_ret_rdfpu;
    end
  end

`ifdef E203_LONGP_WBCK_EXCP_EN
  // Exception payload stored alongside the normal entry
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < BUF_DEPTH; i++) begin
        r_err[i]     <= 1'b0;
        r_badaddr[i] <= '0;
        r_pc[i]      <= '0;
      end
    end else if (w_cap) begin
      r_err[r_wptr]     <= w_src_err[w_sel_idx];
      r_badaddr[r_wptr] <= w_src_badaddr[w_sel_idx];
      r_pc[r_wptr]      <= oitf_ret_pc;
    end
  end
`endif

endmodule

// File: tb/tb_e203_exu_longp_wbck_buf.sv
// Testbench for e203_exu_longp_wbck_buf: directed scenarios plus randomized
// traffic against a queue-based reference model.
`timescale 1ns/1ps
module tb_e203_exu_longp_wbck_buf;
  localparam int NSRC = 2, ITAG_W = 1, XLEN = 32, RFIDX_W = 5, PC_W = 32, BUF_DEPTH = 2;
`ifdef E203_LONGP_WBCK_EXCP_EN
  localparam bit EXCP_EN = 1'b1;
`else
  localparam bit EXCP_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  logic [NSRC-1:0]        src_i_valid;
  logic [NSRC-1:0]        src_i_ready;
  logic [NSRC*ITAG_W-1:0] src_i_itag;
  logic [NSRC*XLEN-1:0]   src_i_wdat;
  logic [NSRC-1:0]        src_i_err;
  logic [NSRC*XLEN-1:0]   src_i_badaddr;
  logic                   oitf_empty;
  logic [ITAG_W-1:0]      oitf_ret_ptr;
  logic [RFIDX_W-1:0]     oitf_ret_rdidx;
  logic                   oitf_ret_rdwen;
  logic                   oitf_ret_rdfpu;
  logic [PC_W-1:0]        oitf_ret_pc;
  logic                   oitf_ret_ena;
  logic                   wbck_o_valid;
  logic                   wbck_o_ready;
  logic [XLEN-1:0]        wbck_o_wdat;
  logic [RFIDX_W-1:0]     wbck_o_rdidx;
  logic                   wbck_o_rdfpu;
  logic                   excp_o_valid;
  logic                   excp_o_ready;
  logic [XLEN-1:0]        excp_o_badaddr;
  logic [PC_W-1:0]        excp_o_pc;
  logic                   buf_empty;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  e203_exu_longp_wbck_buf #(
    .NSRC(NSRC), .ITAG_W(ITAG_W), .XLEN(XLEN), .RFIDX_W(RFIDX_W), .PC_W(PC_W), .BUF_DEPTH(BUF_DEPTH)
  ) dut (
    .clk(clk), .rst(rst),
    .src_i_valid(src_i_valid), .src_i_ready(src_i_ready), .src_i_itag(src_i_itag),
    .src_i_wdat(src_i_wdat), .src_i_err(src_i_err), .src_i_badaddr(src_i_badaddr),
    .oitf_empty(oitf_empty), .oitf_ret_ptr(oitf_ret_ptr), .oitf_ret_rdidx(oitf_ret_rdidx),
    .oitf_ret_rdwen(oitf_ret_rdwen), .oitf_ret_rdfpu(oitf_ret_rdfpu), .oitf_ret_pc(oitf_ret_pc),
    .oitf_ret_ena(oitf_ret_ena),
    .wbck_o_valid(wbck_o_valid), .wbck_o_ready(wbck_o_ready), .wbck_o_wdat(wbck_o_wdat),
    .wbck_o_rdidx(wbck_o_rdidx), .wbck_o_rdfpu(wbck_o_rdfpu),
    .excp_o_valid(excp_o_valid), .excp_o_ready(excp_o_ready),
    .excp_o_badaddr(excp_o_badaddr), .excp_o_pc(excp_o_pc),
    .buf_empty(buf_empty)
  );

  typedef struct packed {
    logic [XLEN-1:0]    wdat;
    logic               err;
    logic [XLEN-1:0]    bad;
    logic [RFIDX_W-1:0] rdidx;
    logic               rdwen;
    logic               rdfpu;
    logic [PC_W-1:0]    pc;
  } ent_t;

  ent_t model_q[$];

  task automatic drive_idle();
    src_i_valid = '0; src_i_itag = '0; src_i_wdat = '0; src_i_err = '0; src_i_badaddr = '0;
    oitf_empty = 1'b0; oitf_ret_ptr = '0; oitf_ret_rdidx = '0; oitf_ret_rdwen = 1'b0;
    oitf_ret_rdfpu = 1'b0; oitf_ret_pc = '0; wbck_o_ready = 1'b0; excp_o_ready = 1'b0;
  endtask

  task automatic set_src(input int i, input logic v, input logic [ITAG_W-1:0] itag,
                         input logic [XLEN-1:0] wdat, input logic err, input logic [XLEN-1:0] bad);
    src_i_valid[i] = v;
    src_i_itag[i*ITAG_W +: ITAG_W] = itag;
    src_i_wdat[i*XLEN +: XLEN] = wdat;
    src_i_err[i] = err;
    src_i_badaddr[i*XLEN +: XLEN] = bad;
  endtask

  task automatic test_reset();
    drive_idle();
    rst = 1'b1;
    #1;
    n_checks++; if (buf_empty !== 1'b1) begin n_fail++; $display("FAIL rst_buf_empty: got %b expected 1", buf_empty); end
    n_checks++; if (oitf_ret_ena !== 1'b0) begin n_fail++; $display("FAIL rst_ret_ena: got %b expected 0", oitf_ret_ena); end
    n_checks++; if (src_i_ready !== 2'b00) begin n_fail++; $display("FAIL rst_ready: got %b expected 00", src_i_ready); end
    n_checks++; if (wbck_o_valid !== 1'b0 || excp_o_valid !== 1'b0) begin n_fail++; $display("FAIL rst_valids: got wbck=%b excp=%b expected 0/0", wbck_o_valid, excp_o_valid); end
    n_checks++; if (wbck_o_wdat !== 32'h0 || wbck_o_rdidx !== 5'h0 || wbck_o_rdfpu !== 1'b0) begin n_fail++; $display("FAIL rst_wbck_data: got %h/%h/%b expected zeros", wbck_o_wdat, wbck_o_rdidx, wbck_o_rdfpu); end
    n_checks++; if (excp_o_badaddr !== 32'h0 || excp_o_pc !== 32'h0) begin n_fail++; $display("FAIL rst_excp_data: got %h/%h expected zeros", excp_o_badaddr, excp_o_pc); end
    @(negedge clk);
    rst = 1'b0;
    $display("[%0t] reset released", $time);
  endtask

  task automatic test_in_order();
    @(negedge clk);
    drive_idle();
    oitf_ret_ptr = 1'b0; oitf_ret_rdidx = 5'd5; oitf_ret_rdwen = 1'b1; oitf_ret_pc = 32'h40;
    wbck_o_ready = 1'b1;
    set_src(0, 1'b1, 1'b0, 32'h1234, 1'b0, 32'h0);
    set_src(1, 1'b1, 1'b1, 32'hABCD, 1'b0, 32'h0);
    #1;
    n_checks++; if (src_i_ready !== 2'b01) begin n_fail++; $display("FAIL inord_ready0: got %b expected 01", src_i_ready); end
    n_checks++; if (oitf_ret_ena !== 1'b1) begin n_fail++; $display("FAIL inord_ena0: got %b expected 1", oitf_ret_ena); end
    @(negedge clk);
    oitf_ret_ptr = 1'b1; oitf_ret_rdidx = 5'd6;
    set_src(0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    #1;
    n_checks++; if (wbck_o_valid !== 1'b1 || wbck_o_wdat !== 32'h1234 || wbck_o_rdidx !== 5'd5) begin n_fail++; $display("FAIL inord_wb0: got v=%b wdat=%h rd=%0d expected 1/1234/5", wbck_o_valid, wbck_o_wdat, wbck_o_rdidx); end
    n_checks++; if (src_i_ready !== 2'b10 || oitf_ret_ena !== 1'b1) begin n_fail++; $display("FAIL inord_ready1: got %b ena=%b expected 10/1", src_i_ready, oitf_ret_ena); end
    @(negedge clk);
    set_src(1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    #1;
    n_checks++; if (wbck_o_valid !== 1'b1 || wbck_o_wdat !== 32'hABCD || wbck_o_rdidx !== 5'd6) begin n_fail++; $display("FAIL inord_wb1: got v=%b wdat=%h rd=%0d expected 1/abcd/6", wbck_o_valid, wbck_o_wdat, wbck_o_rdidx); end
    @(negedge clk);
    #1;
    n_checks++; if (buf_empty !== 1'b1 || wbck_o_valid !== 1'b0) begin n_fail++; $display("FAIL inord_drained: got empty=%b v=%b expected 1/0", buf_empty, wbck_o_valid); end
    $display("[%0t] in-order retire: two results written back", $time);
  endtask

  task automatic test_backpressure();
    logic [ITAG_W-1:0] p;
    p = 1'b0;
    @(negedge clk);
    drive_idle();
    oitf_ret_rdwen = 1'b1; oitf_ret_ptr = p;
    set_src(0, 1'b1, p, 32'h11, 1'b0, 32'h0);
    #1;
    n_checks++; if (src_i_ready !== 2'b01) begin n_fail++; $display("FAIL bp_cap1: got %b expected 01", src_i_ready); end
    p = ~p;
    @(negedge clk);
    oitf_ret_ptr = p; set_src(0, 1'b1, p, 32'h22, 1'b0, 32'h0);
    #1;
    n_checks++; if (src_i_ready !== 2'b01 || wbck_o_wdat !== 32'h11) begin n_fail++; $display("FAIL bp_cap2: got rdy=%b wdat=%h expected 01/11", src_i_ready, wbck_o_wdat); end
    p = ~p;
    @(negedge clk);
    oitf_ret_ptr = p; set_src(0, 1'b1, p, 32'h33, 1'b0, 32'h0);
    #1;
    n_checks++; if (src_i_ready !== 2'b00 || oitf_ret_ena !== 1'b0) begin n_fail++; $display("FAIL bp_full_hold: got rdy=%b ena=%b expected 00/0", src_i_ready, oitf_ret_ena); end
    n_checks++; if (wbck_o_valid !== 1'b1 || wbck_o_wdat !== 32'h11) begin n_fail++; $display("FAIL bp_head: got v=%b wdat=%h expected 1/11", wbck_o_valid, wbck_o_wdat); end
    @(negedge clk);
    wbck_o_ready = 1'b1;
    #1;
    n_checks++; if (src_i_ready !== 2'b00 || wbck_o_wdat !== 32'h11) begin n_fail++; $display("FAIL bp_pop_only: got rdy=%b wdat=%h expected 00/11", src_i_ready, wbck_o_wdat); end
    @(negedge clk);
    #1;
    n_checks++; if (src_i_ready !== 2'b01 || oitf_ret_ena !== 1'b1 || wbck_o_wdat !== 32'h22) begin n_fail++; $display("FAIL bp_third_cap: got rdy=%b ena=%b wdat=%h expected 01/1/22", src_i_ready, oitf_ret_ena, wbck_o_wdat); end
    @(negedge clk);
    set_src(0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    #1;
    n_checks++; if (wbck_o_valid !== 1'b1 || wbck_o_wdat !== 32'h33) begin n_fail++; $display("FAIL bp_third_out: got v=%b wdat=%h expected 1/33", wbck_o_valid, wbck_o_wdat); end
    @(negedge clk);
    #1;
    n_checks++; if (buf_empty !== 1'b1) begin n_fail++; $display("FAIL bp_drained: got %b expected 1", buf_empty); end
    $display("[%0t] backpressure: three results drained in order", $time);
  endtask

  task automatic test_error_path();
    logic exp_e;
    exp_e = EXCP_EN;
    @(negedge clk);
    drive_idle();
    oitf_ret_rdwen = 1'b1; oitf_ret_rdidx = 5'd7; oitf_ret_pc = 32'h100;
    set_src(0, 1'b1, 1'b0, 32'h55, 1'b1, 32'h8000_0004);
    #1;
    n_checks++; if (oitf_ret_ena !== 1'b1) begin n_fail++; $display("FAIL err_cap: got %b expected 1", oitf_ret_ena); end
    @(negedge clk);
    set_src(0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    #1;
    n_checks++; if (excp_o_valid !== exp_e || wbck_o_valid !== ~exp_e) begin n_fail++; $display("FAIL err_valids: got excp=%b wbck=%b expected %b/%b", excp_o_valid, wbck_o_valid, exp_e, ~exp_e); end
    n_checks++; if (excp_o_badaddr !== (exp_e ? 32'h8000_0004 : 32'h0) || excp_o_pc !== (exp_e ? 32'h100 : 32'h0)) begin n_fail++; $display("FAIL err_payload: got bad=%h pc=%h", excp_o_badaddr, excp_o_pc); end
    n_checks++; if (wbck_o_wdat !== 32'h55 || wbck_o_rdidx !== 5'd7) begin n_fail++; $display("FAIL err_head_data: got %h/%0d expected 55/7", wbck_o_wdat, wbck_o_rdidx); end
    @(negedge clk);
    excp_o_ready = 1'b1;
    #1;
    n_checks++; if (excp_o_valid !== exp_e || buf_empty !== 1'b0) begin n_fail++; $display("FAIL err_held: got excp=%b empty=%b expected %b/0", excp_o_valid, buf_empty, exp_e); end
    @(negedge clk);
    excp_o_ready = 1'b0; wbck_o_ready = 1'b1;
    #1;
    n_checks++; if (buf_empty !== exp_e) begin n_fail++; $display("FAIL err_excp_pop: got empty=%b expected %b", buf_empty, exp_e); end
    @(negedge clk);
    #1;
    n_checks++; if (buf_empty !== 1'b1) begin n_fail++; $display("FAIL err_drained: got %b expected 1", buf_empty); end
    $display("[%0t] error result retired (exception path %0d)", $time, exp_e);
  endtask

  task automatic test_silent_drop();
    @(negedge clk);
    drive_idle();
    oitf_ret_rdwen = 1'b0;
    set_src(1, 1'b1, 1'b0, 32'h77, 1'b0, 32'h0);
    #1;
    n_checks++; if (oitf_ret_ena !== 1'b1 || src_i_ready !== 2'b10) begin n_fail++; $display("FAIL drop_cap: got ena=%b rdy=%b expected 1/10", oitf_ret_ena, src_i_ready); end
    @(negedge clk);
    set_src(1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    #1;
    n_checks++; if (buf_empty !== 1'b0 || wbck_o_valid !== 1'b0 || excp_o_valid !== 1'b0) begin n_fail++; $display("FAIL drop_head: got empty=%b wbck=%b excp=%b expected 0/0/0", buf_empty, wbck_o_valid, excp_o_valid); end
    @(negedge clk);
    #1;
    n_checks++; if (buf_empty !== 1'b1) begin n_fail++; $display("FAIL drop_gone: got %b expected 1", buf_empty); end
    $display("[%0t] silent drop of no-rd result", $time);
  endtask

  task automatic test_async_reset();
    @(negedge clk);
    drive_idle();
    oitf_ret_rdwen = 1'b1; oitf_ret_rdidx = 5'd9;
    set_src(0, 1'b1, 1'b0, 32'hA1, 1'b0, 32'h0);
    @(negedge clk);
    oitf_ret_ptr = 1'b1; set_src(0, 1'b1, 1'b1, 32'hA2, 1'b0, 32'h0);
    @(negedge clk);
    set_src(0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    #1;
    n_checks++; if (buf_empty !== 1'b0 || wbck_o_valid !== 1'b1 || wbck_o_wdat !== 32'hA1) begin n_fail++; $display("FAIL arst_pre: got empty=%b v=%b wdat=%h expected 0/1/a1", buf_empty, wbck_o_valid, wbck_o_wdat); end
    wbck_o_ready = 1'b1;
    #2;
    rst = 1'b1;
    #1;
    n_checks++; if (buf_empty !== 1'b1 || wbck_o_valid !== 1'b0) begin n_fail++; $display("FAIL arst_now: got empty=%b v=%b expected 1/0", buf_empty, wbck_o_valid); end
    n_checks++; if (wbck_o_wdat !== 32'h0 || wbck_o_rdidx !== 5'h0 || oitf_ret_ena !== 1'b0) begin n_fail++; $display("FAIL arst_data: got wdat=%h rd=%0d ena=%b expected 0/0/0", wbck_o_wdat, wbck_o_rdidx, oitf_ret_ena); end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    #1;
    n_checks++; if (buf_empty !== 1'b1 || wbck_o_valid !== 1'b0) begin n_fail++; $display("FAIL arst_after: got empty=%b v=%b expected 1/0", buf_empty, wbck_o_valid); end
    $display("[%0t] async reset discarded queued entries", $time);
  endtask

  task automatic test_random(input int ncyc);
    int   idx;
    bit   exp_full, exp_pop;
    logic [NSRC-1:0] exp_rdy;
    ent_t h, e;
    @(negedge clk);
    drive_idle();
    rst = 1'b1;
    #2;
    rst = 1'b0;
    model_q.delete();
    for (int c = 0; c < ncyc; c++) begin
      @(negedge clk);
      oitf_empty     = ($urandom_range(0, 7) == 0);
      oitf_ret_ptr   = ITAG_W'($urandom_range(0, (1 << ITAG_W) - 1));
      oitf_ret_rdidx = RFIDX_W'($urandom);
      oitf_ret_rdwen = ($urandom_range(0, 3) != 0);
      oitf_ret_rdfpu = ($urandom_range(0, 1) != 0);
      oitf_ret_pc    = PC_W'($urandom);
      wbck_o_ready   = ($urandom_range(0, 2) != 0);
      excp_o_ready   = ($urandom_range(0, 2) != 0);
      for (int i = 0; i < NSRC; i++)
        set_src(i, ($urandom_range(0, 3) != 0), ITAG_W'($urandom_range(0, (1 << ITAG_W) - 1)),
                $urandom, ($urandom_range(0, 3) == 0), $urandom);
      #1;
      // Model: first matching source wins when the queue has room
      idx = -1;
      for (int i = NSRC - 1; i >= 0; i--)
        if (src_i_valid[i] && !oitf_empty && src_i_itag[i*ITAG_W +: ITAG_W] == oitf_ret_ptr) idx = i;
      exp_full = (model_q.size() == BUF_DEPTH);
      exp_rdy  = (idx >= 0 && !exp_full) ? NSRC'(1 << idx) : '0;
      n_checks++; if (src_i_ready !== exp_rdy || oitf_ret_ena !== (idx >= 0 && !exp_full)) begin n_fail++; $display("FAIL rnd_accept c%0d: got rdy=%b ena=%b expected %b/%b", c, src_i_ready, oitf_ret_ena, exp_rdy, (idx >= 0 && !exp_full)); end
      n_checks++; if (buf_empty !== (model_q.size() == 0)) begin n_fail++; $display("FAIL rnd_empty c%0d: got %b expected %b", c, buf_empty, (model_q.size() == 0)); end
      exp_pop = 1'b0;
      if (model_q.size() > 0) begin
        h = model_q[0];
        n_checks++; if (wbck_o_valid !== (!h.err && h.rdwen) || excp_o_valid !== h.err) begin n_fail++; $display("FAIL rnd_valids c%0d: got wbck=%b excp=%b expected %b/%b", c, wbck_o_valid, excp_o_valid, (!h.err && h.rdwen), h.err); end
        if (!h.err && h.rdwen) begin
          n_checks++; if (wbck_o_wdat !== h.wdat || wbck_o_rdidx !== h.rdidx || wbck_o_rdfpu !== h.rdfpu) begin n_fail++; $display("FAIL rnd_wbck c%0d: got %h/%0d/%b expected %h/%0d/%b", c, wbck_o_wdat, wbck_o_rdidx, wbck_o_rdfpu, h.wdat, h.rdidx, h.rdfpu); end
        end
        if (h.err) begin
          n_checks++; if (excp_o_badaddr !== h.bad || excp_o_pc !== h.pc) begin n_fail++; $display("FAIL rnd_excp c%0d: got %h/%h expected %h/%h", c, excp_o_badaddr, excp_o_pc, h.bad, h.pc); end
        end
        exp_pop = h.err ? excp_o_ready : (h.rdwen ? wbck_o_ready : 1'b1);
      end else begin
        n_checks++; if (wbck_o_valid !== 1'b0 || excp_o_valid !== 1'b0) begin n_fail++; $display("FAIL rnd_idle c%0d: got wbck=%b excp=%b expected 0/0", c, wbck_o_valid, excp_o_valid); end
      end
`ifndef E203_LONGP_WBCK_EXCP_EN
      n_checks++; if (excp_o_badaddr !== 32'h0 || excp_o_pc !== 32'h0) begin n_fail++; $display("FAIL rnd_excp_tied c%0d: got %h/%h expected 0/0", c, excp_o_badaddr, excp_o_pc); end
`endif
      if (exp_pop) begin
        $display("[%0t] pop %s wdat=%h rd=%0d", $time, h.err ? "excp" : (h.rdwen ? "wbck" : "drop"), h.wdat, h.rdidx);
        void'(model_q.pop_front());
      end
      if (idx >= 0 && !exp_full) begin
        e.wdat  = src_i_wdat[idx*XLEN +: XLEN];
        e.err   = EXCP_EN ? src_i_err[idx] : 1'b0;
        e.bad   = src_i_badaddr[idx*XLEN +: XLEN];
        e.rdidx = oitf_ret_rdidx;
        e.rdwen = oitf_ret_rdwen;
        e.rdfpu = oitf_ret_rdfpu;
        e.pc    = oitf_ret_pc;
        model_q.push_back(e);
      end
    end
  endtask

  initial begin
    test_reset();
    test_in_order();
    test_backpressure();
    test_error_path();
    test_silent_drop();
    test_async_reset();
    test_random(800);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
